// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared opcodes, FSM states and timing constants for muldiv_unit
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } muldiv_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    localparam int MULDIV_ITER    = 32;
    localparam int MULDIV_LATENCY = 33;

endpackage

// File: rtl/udiv_step.sv
// rtl/udiv_step.sv - one combinational restoring-divide iteration on a packed {rem, quot} pair
module udiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] rq_i,
    input  logic [WIDTH-1:0]   divisor_i,
    output logic [2*WIDTH-1:0] rq_o
);

    logic [WIDTH:0]   part;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Partial remainder shifted left with the next dividend bit; one extra bit so it cannot overflow.
    assign part = {rq_i[2*WIDTH-1:WIDTH], rq_i[WIDTH-1]};
    assign fits = (part >= {1'b0, divisor_i});
    assign diff = part[WIDTH-1:0] - divisor_i;

    assign rq_o = {(fits ? diff : part[WIDTH-1:0]), rq_i[WIDTH-2:0], fits};

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; MULDIV_DIV0_TRAP_EN adds a div0 trap
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             busy,
    output logic             done,
`ifdef MULDIV_DIV0_TRAP_EN
    output logic             div0,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    if (WIDTH != 32) begin : g_width_check
        $error("muldiv_unit supports WIDTH=32 only");
    end

    state_e             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
`ifdef MULDIV_DIV0_TRAP_EN
    logic               div0_q, div0_d;
    logic               trap_q, trap_d;
`endif

    logic               req_signed, req_div, a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign req_signed = (op == OP_MULT) || (op == OP_DIV);
    assign req_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign a_neg      = req_signed & op1[WIDTH-1];
    assign b_neg      = req_signed & op2[WIDTH-1];
    assign a_abs      = a_neg ? -op1 : op1;
    assign b_abs      = b_neg ? -op2 : op2;

    // Shift-add multiply: acc = {partial product, remaining multiplier bits}.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    udiv_step #(.WIDTH(WIDTH)) u_step (
        .rq_i      (acc_q),
        .divisor_i (opb_q),
        .rq_o      (div_next)
    );

    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign quot_fix = dz_q ? '1 : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
`ifdef MULDIV_DIV0_TRAP_EN
        div0_d    = 1'b0;
        trap_d    = trap_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_d   = S_RUN;
                            busy_d    = 1'b1;
                            cnt_d     = '0;
                            is_div_d  = req_div;
                            neg_res_d = a_neg ^ b_neg;
                            neg_rem_d = a_neg;
                            dz_d      = req_div && (op2 == '0);
                            opb_d     = req_div ? b_abs : a_abs;
                            acc_d     = {{WIDTH{1'b0}}, (req_div ? a_abs : b_abs)};
`ifdef MULDIV_DIV0_TRAP_EN
                            trap_d    = 1'b0;
                            if (req_div && (op2 == '0)) begin
                                state_d = S_FIX;
                                busy_d  = 1'b0;
                                trap_d  = 1'b1;
                            end
`endif
                        end
                        OP_MTHI: hi_d = op1;
                        OP_MTLO: lo_d = op1;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(MULDIV_ITER - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
`ifdef MULDIV_DIV0_TRAP_EN
                if (trap_q) begin
                    div0_d = 1'b1;
                    trap_d = 1'b0;
                end else
`endif
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
`ifdef MULDIV_DIV0_TRAP_EN
            div0_q    <= 1'b0;
            trap_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
`ifdef MULDIV_DIV0_TRAP_EN
            div0_q    <= div0_d;
            trap_q    <= trap_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
`ifdef MULDIV_DIV0_TRAP_EN
    assign div0 = div0_q;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit (default and MULDIV_DIV0_TRAP_EN builds)
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] op1, op2;
    logic        busy, done;
    logic [31:0] hi, lo;
`ifdef MULDIV_DIV0_TRAP_EN
    logic        div0;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        int          e_lat;
        int          e_busy;
        bit          e_trap;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mdl_hi = '0;
    logic [31:0] mdl_lo = '0;

    muldiv_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .op1   (op1),
        .op2   (op2),
        .busy  (busy),
        .done  (done),
`ifdef MULDIV_DIV0_TRAP_EN
        .div0  (div0),
`endif
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub, p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        h  = '0;
        l  = '0;
        case (o)
            3'd0: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            3'd1: begin p = ua * ub; h = p[63:32]; l = p[31:0]; end
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    h = a;
                    l = 32'hFFFF_FFFF;
                end else if (o == 3'd2) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    h  = sr[31:0];
                    l  = sq[31:0];
                end else begin
                    p = ua / ub;
                    l = p[31:0];
                    p = ua % ub;
                    h = p[31:0];
                end
            end
            default: ;
        endcase
    endfunction

    task automatic do_op(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit inject);
        exp_t        e;
        logic [31:0] h, l;
        int          n, busy_n;
        bit          stable, trap;
        trap = 1'b0;
`ifdef MULDIV_DIV0_TRAP_EN
        trap = ((o == 3'd2) || (o == 3'd3)) && (b == 32'd0);
`endif
        model(o, a, b, h, l);
        e.e_trap = trap;
        if (trap) begin
            e.e_hi = mdl_hi; e.e_lo = mdl_lo; e.e_lat = 1; e.e_busy = 0;
        end else begin
            e.e_hi = h; e.e_lo = l; e.e_lat = MULDIV_LATENCY; e.e_busy = MULDIV_ITER + 1;
        end
        sb_q.push_back(e);

        @(negedge clk);
        start = 1'b1; op = o; op1 = a; op2 = b;
        @(posedge clk); #1;
        start  = 1'b0;
        busy_n = busy ? 1 : 0;
        n      = 0;
        stable = 1'b1;
        while (!done && n < 60) begin
            if (inject && n == 4) begin
                start = 1'b1; op = OP_MTHI; op1 = 32'hDEAD_BEEF;
            end
            @(posedge clk); #1;
            n++;
            if (inject && n == 5) start = 1'b0;
            if (!done) begin
                busy_n += busy ? 1 : 0;
                if (hi !== mdl_hi || lo !== mdl_lo) stable = 1'b0;
            end
        end
        e = sb_q.pop_front();
        check_eq({name, " latency"}, 64'(n), 64'(e.e_lat));
        check_eq({name, " busy_cycles"}, 64'(busy_n), 64'(e.e_busy));
        check_eq({name, " hold_during_run"}, 64'(stable), 64'd1);
        check_eq({name, " busy_at_done"}, 64'(busy), 64'd0);
        check_eq({name, " hi"}, 64'(hi), 64'(e.e_hi));
        check_eq({name, " lo"}, 64'(lo), 64'(e.e_lo));
        if (inject) check_eq({name, " mthi_ignored"}, 64'(hi == 32'hDEAD_BEEF), 64'd0);
`ifdef MULDIV_DIV0_TRAP_EN
        check_eq({name, " div0"}, 64'(div0), 64'(e.e_trap));
`endif
        @(posedge clk); #1;
        check_eq({name, " done_pulse"}, 64'(done), 64'd0);
`ifdef MULDIV_DIV0_TRAP_EN
        check_eq({name, " div0_pulse"}, 64'(div0), 64'd0);
`endif
        mdl_hi = e.e_hi;
        mdl_lo = e.e_lo;
    endtask

    initial begin
        bit          seen_done;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        rst_n = 1'b0; start = 1'b0; op = '0; op1 = '0; op2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset busy", 64'(busy), 64'd0);
        check_eq("reset done", 64'(done), 64'd0);
        check_eq("reset hi", 64'(hi), 64'd0);
        check_eq("reset lo", 64'(lo), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        // MTLO then MTHI back to back
        @(negedge clk);
        start = 1'b1; op = OP_MTLO; op1 = 32'h1234_5678;
        @(posedge clk); #1;
        check_eq("mtlo lo", 64'(lo), 64'h1234_5678);
        check_eq("mtlo busy", 64'(busy), 64'd0);
        check_eq("mtlo done", 64'(done), 64'd0);
        op = OP_MTHI; op1 = 32'hCAFE_F00D;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("mthi hi", 64'(hi), 64'hCAFE_F00D);
        check_eq("mthi lo_kept", 64'(lo), 64'h1234_5678);
        check_eq("mthi busy", 64'(busy), 64'd0);
        check_eq("mthi done", 64'(done), 64'd0);
        mdl_hi = 32'hCAFE_F00D;
        mdl_lo = 32'h1234_5678;

        // reserved opcode does nothing
        @(negedge clk);
        start = 1'b1; op = 3'b110; op1 = 32'h5555_AAAA; op2 = 32'h1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("op110 hi", 64'(hi), 64'(mdl_hi));
        check_eq("op110 lo", 64'(lo), 64'(mdl_lo));
        check_eq("op110 busy", 64'(busy), 64'd0);

        do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op("mult_neg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
        do_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 1'b0);
        do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op("mult_min_sq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
        do_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 1'b0);
        do_op("div_7_m3", OP_DIV, 32'd7, 32'hFFFF_FFFD, 1'b0);

        for (int i = 0; i < 8; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
            do_op($sformatf("rand%0d", i), ro, ra, rb, 1'b0);
        end

        // async reset in the middle of RUN
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; op1 = 32'hFFFF_FFFF; op2 = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_eq("midrst busy", 64'(busy), 64'd0);
        check_eq("midrst done", 64'(done), 64'd0);
        check_eq("midrst hi", 64'(hi), 64'd0);
        check_eq("midrst lo", 64'(lo), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        check_eq("midrst no_done", 64'(seen_done), 64'd0);
        check_eq("midrst hi_after", 64'(hi), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
